// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive front end (NRZI decode + bit destuffing).
package usb_rx_pkg;

  // Encoded as {dp, dm} so the raw pins cast directly onto the enum.
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    K   = 2'b01,
    J   = 2'b10,
    SE1 = 2'b11
  } bus_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RECV,
    ST_EOP1,
    ST_EOP2
  } rx_state_t;

  localparam int SYNC_LEN  = 8;
  localparam int STUFF_RUN = 6;

endpackage

// File: rtl/usb_rx_nrzi_destuff_nrzi_decode.sv
// Bus-state classifier and NRZI decoder; tracks the last non-SE0 line level.
module nrzi_decode
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_L,
  input  logic       dp_in,
  input  logic       dm_in,
  input  logic       rx_en,
  input  logic       in_idle,
  output bus_state_t bus_state,
  output logic       is_se0,
  output logic       dec_bit
);

  bus_state_t prev_q, prev_d;
  bus_state_t level;

  always_comb begin
    bus_state = bus_state_t'({dp_in, dm_in});
    is_se0    = (bus_state == SE0) || (bus_state == SE1);
    level     = (bus_state == J) ? J : K;
    dec_bit   = (level == prev_q);
  end

  // SE0 holds the last level mid-packet; an idle or disabled receiver re-arms to J.
  always_comb begin
    prev_d = prev_q;
    if (!rx_en) begin
      prev_d = J;
    end else if (is_se0) begin
      if (in_idle) begin
        prev_d = J;
      end
    end else begin
      prev_d = level;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      prev_q <= J;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/usb_rx_nrzi_destuff.sv
// USB receive front end: SYNC hunt, NRZI decode, bit destuffing and EOP detection.
// Define USB_RX_STUFF_ERR_EN to treat a 1 in a stuffed-bit slot as a stuff error.
module usb_rx_nrzi_destuff
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_L,
  input  logic dp_in,
  input  logic dm_in,
  input  logic rx_en,
  output logic inb,
  output logic recving,
  output logic pause,
  output logic rx_error
);

  rx_state_t  state_q, state_d;
  logic [2:0] sync_cnt_q, sync_cnt_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic       inb_q, inb_d;
  logic       recving_q, recving_d;
  logic       pause_q, pause_d;
  logic       rx_error_q, rx_error_d;

  bus_state_t bus_state;
  logic       is_se0;
  logic       dec_bit;
  logic       in_idle;
  logic       stuff_bit;

  assign in_idle   = (state_q == ST_IDLE);
  assign stuff_bit = (ones_cnt_q == 3'(STUFF_RUN));

  nrzi_decode u_nrzi_decode (
    .clk       (clk),
    .rst_L     (rst_L),
    .dp_in     (dp_in),
    .dm_in     (dm_in),
    .rx_en     (rx_en),
    .in_idle   (in_idle),
    .bus_state (bus_state),
    .is_se0    (is_se0),
    .dec_bit   (dec_bit)
  );

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= ST_IDLE;
      sync_cnt_q <= '0;
      ones_cnt_q <= '0;
      inb_q      <= 1'b0;
      recving_q  <= 1'b0;
      pause_q    <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      inb_q      <= inb_d;
      recving_q  <= recving_d;
      pause_q    <= pause_d;
      rx_error_q <= rx_error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    ones_cnt_d = ones_cnt_q;
    if (!rx_en) begin
      state_d    = ST_IDLE;
      sync_cnt_d = '0;
      ones_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sync_cnt_d = '0;
          ones_cnt_d = '0;
          // A K following J decodes as 0: the first SYNC bit.
          if (bus_state == K && !dec_bit) begin
            state_d    = ST_SYNC;
            sync_cnt_d = 3'd1;
          end
        end
        ST_SYNC: begin
          if (is_se0) begin
            state_d    = ST_IDLE;
            sync_cnt_d = '0;
          end else if (sync_cnt_q == 3'(SYNC_LEN - 1)) begin
            state_d    = dec_bit ? ST_RECV : ST_IDLE;
            sync_cnt_d = '0;
            ones_cnt_d = '0;
          end else if (!dec_bit) begin
            sync_cnt_d = sync_cnt_q + 3'd1;
          end else begin
            state_d    = ST_IDLE;
            sync_cnt_d = '0;
          end
        end
        ST_RECV: begin
          if (is_se0) begin
            state_d    = ST_EOP1;
            ones_cnt_d = '0;
          end else if (stuff_bit) begin
            ones_cnt_d = '0;
`ifdef USB_RX_STUFF_ERR_EN
            if (dec_bit) begin
              state_d = ST_IDLE;
            end
`endif
          end else if (dec_bit) begin
            ones_cnt_d = ones_cnt_q + 3'd1;
          end else begin
            ones_cnt_d = '0;
          end
        end
        ST_EOP1: state_d = is_se0 ? ST_EOP2 : ST_IDLE;
        ST_EOP2: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    inb_d      = 1'b0;
    recving_d  = 1'b0;
    pause_d    = 1'b0;
    rx_error_d = 1'b0;
    if (rx_en) begin
      case (state_q)
        ST_RECV: begin
          // SE0 drops recving with no pause even when a stuffed bit was due.
          if (!is_se0) begin
`ifdef USB_RX_STUFF_ERR_EN
            if (stuff_bit && dec_bit) begin
              rx_error_d = 1'b1;
            end else begin
              recving_d = 1'b1;
              inb_d     = dec_bit;
              pause_d   = stuff_bit;
            end
`else
            recving_d = 1'b1;
            inb_d     = dec_bit;
            pause_d   = stuff_bit;
`endif
          end
        end
        ST_EOP1: rx_error_d = !is_se0;
        ST_EOP2: rx_error_d = (bus_state != J);
        default: ;
      endcase
    end
  end

  assign inb      = inb_q;
  assign recving  = recving_q;
  assign pause    = pause_q;
  assign rx_error = rx_error_q;

endmodule

// File: tb/tb_usb_rx_nrzi_destuff.sv
// Directed self-checking bench for usb_rx_nrzi_destuff; honours USB_RX_STUFF_ERR_EN.
module tb_usb_rx_nrzi_destuff;

  logic clk;
  logic rst_L;
  logic dp_in;
  logic dm_in;
  logic rx_en;
  logic inb;
  logic recving;
  logic pause;
  logic rx_error;

  typedef struct {
    logic  recv;
    logic  inb;
    logic  pause;
    logic  err;
    string tag;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;
  bit   lineJ       = 1'b1;
  int   onesRun     = 0;

  usb_rx_nrzi_destuff dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .dp_in    (dp_in),
    .dm_in    (dm_in),
    .rx_en    (rx_en),
    .inb      (inb),
    .recving  (recving),
    .pause    (pause),
    .rx_error (rx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkZeros(input string tag);
    assertCount++;
    assert (recving === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL %s recving observed=%b expected=0", tag, recving);
    end
    assertCount++;
    assert (pause === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL %s pause observed=%b expected=0", tag, pause);
    end
    assertCount++;
    assert (rx_error === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL %s rx_error observed=%b expected=0", tag, rx_error);
    end
    assertCount++;
    assert (inb === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL %s inb observed=%b expected=0", tag, inb);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = expQ.pop_front();
    assertCount++;
    assert (recving === e.recv) else begin
      failCount++;
      $error("[TB] FAIL %s recving observed=%b expected=%b", e.tag, recving, e.recv);
    end
    assertCount++;
    assert (pause === e.pause) else begin
      failCount++;
      $error("[TB] FAIL %s pause observed=%b expected=%b", e.tag, pause, e.pause);
    end
    assertCount++;
    assert (rx_error === e.err) else begin
      failCount++;
      $error("[TB] FAIL %s rx_error observed=%b expected=%b", e.tag, rx_error, e.err);
    end
    if (e.recv && !e.pause) begin
      assertCount++;
      assert (inb === e.inb) else begin
        failCount++;
        $error("[TB] FAIL %s inb observed=%b expected=%b", e.tag, inb, e.inb);
      end
    end
  endtask

  // Drive one bus sample, queue what the registered outputs must show one cycle later.
  task automatic applyStimulus(input logic [1:0] lvl, input logic er, input logic ei,
                               input logic ep, input logic ee, input string tag);
    exp_t e;
    dp_in = lvl[1];
    dm_in = lvl[0];
    e.recv  = er;
    e.inb   = ei;
    e.pause = ep;
    e.err   = ee;
    e.tag   = tag;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic sendNrzi(input bit b, input logic er, input logic ei,
                          input logic ep, input logic ee, input string tag);
    if (!b) lineJ = !lineJ;
    applyStimulus(lineJ ? 2'b10 : 2'b01, er, ei, ep, ee, tag);
  endtask

  task automatic sendIdle(input int n);
    lineJ = 1'b1;
    repeat (n) applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic sendSync();
    for (int i = 0; i < 8; i++) sendNrzi(i == 7, 1'b0, 1'b0, 1'b0, 1'b0, "sync");
    onesRun = 0;
  endtask

  // Transmitter-side stuffing: after six 1s a 0 is inserted and must appear as a pause cycle.
  task automatic sendData(input bit b);
    sendNrzi(b, 1'b1, b, 1'b0, 1'b0, "data");
    onesRun = b ? onesRun + 1 : 0;
    if (onesRun == 6) begin
      sendNrzi(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "stuff");
      onesRun = 0;
    end
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) sendData(v[i]);
  endtask

  task automatic sendEop();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "eop_se0a");
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "eop_se0b");
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, "eop_j");
    lineJ = 1'b1;
  endtask

  initial begin
    rst_L = 1'b1;
    rx_en = 1'b1;
    dp_in = 1'b1;
    dm_in = 1'b0;
    #2 rst_L = 1'b0;
    #2 checkZeros("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_L = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] valid ACK");
    sendIdle(4);
    sendSync();
    sendByte(8'hD2);
    sendEop();
    sendIdle(2);

    $display("[TB] bit stuffing");
    sendSync();
    repeat (6) sendData(1'b1);
    sendData(1'b0);
    sendEop();
    sendIdle(2);

    $display("[TB] seven ones");
    sendSync();
    for (int i = 0; i < 6; i++) sendNrzi(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "ones");
`ifdef USB_RX_STUFF_ERR_EN
    sendNrzi(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "stuff_err");
    sendEop();
`else
    sendNrzi(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "stuff_discard");
    onesRun = 0;
    sendData(1'b0);
    sendEop();
`endif
    sendIdle(2);

    $display("[TB] bad SYNC");
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, "badsync");
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, "badsync");
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, "badsync");
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, "badsync");
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, "badsync");
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, "badsync");
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, "badsync");
    sendIdle(2);
    sendSync();
    sendByte(8'hA5);
    sendEop();
    sendIdle(2);

    $display("[TB] malformed EOP in second SE0 slot");
    sendSync();
    sendByte(8'h4B);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "eop_se0a");
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "eop_se0b");
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, "bad_eop2");
    sendIdle(3);

    $display("[TB] malformed EOP with single SE0");
    sendSync();
    sendByte(8'h5A);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "eop_se0a");
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, "bad_eop1");
    sendIdle(3);

    $display("[TB] reset mid-packet");
    sendSync();
    for (int i = 0; i < 20; i++) sendData(1'($urandom_range(0, 1)));
    rst_L = 1'b0;
    #1 checkZeros("async_reset");
    dp_in = 1'b1;
    dm_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkZeros("held_reset");
    @(negedge clk);
    rst_L = 1'b1;
    @(posedge clk);
    #1;
    sendIdle(2);
    sendSync();
    sendByte(8'hC3);
    for (int i = 0; i < 80; i++) sendData(1'($urandom_range(0, 1)));
    sendEop();
    sendIdle(2);

    $display("[TB] rx_en drop mid-packet");
    sendSync();
    sendByte(8'h69);
    rx_en = 1'b0;
    sendNrzi(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rx_en_drop");
    rx_en = 1'b1;
    sendIdle(3);
    sendSync();
    sendByte(8'hE1);
    sendEop();
    sendIdle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
